up_down_counter: RTL and testbench
==================================

// Module: up_down_counter
//
// PURPOSE
//   Free-running WIDTH-bit binary up/down counter with hold (pause) control.
//   Counts once per rising clk edge: up when UP_DOWN=1, down when UP_DOWN=0.
//   Wraps modulo 2**WIDTH in both directions.
//   Standalone leaf block, used as a demo counter or as an event/position
//   counter feeding display or compare logic.
//
// PARAMETERS
//   WIDTH   4   counter width in bits; Q range 0 .. 2**WIDTH-1
//
// PORTS
//   clk      in   1      system clock; all state updates on the rising edge
//   reset    in   1      asynchronous, active-high reset; forces Q to 0
//   UP_DOWN  in   1      direction: 1 = increment, 0 = decrement
//   pause    in   1      1 = hold current count; 0 = count
//   Q        out  WIDTH  current count, driven directly from the register
//
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-high.
//   - reset=1: Q goes to 0 immediately, with no clock edge needed. Q stays 0
//     while reset is held, whatever pause and UP_DOWN are doing.
//   - After reset deasserts, Q changes only on rising clk edges.
//   - Priority at each rising edge: reset > pause > direction.
//       pause=1              -> Q <= Q (hold)
//       pause=0, UP_DOWN=1   -> Q <= Q + 1 (mod 2**WIDTH)
//       pause=0, UP_DOWN=0   -> Q <= Q - 1 (mod 2**WIDTH)
//   - Wrap-around, no saturation:
//       up:   2**WIDTH-1 -> 0   (e.g. 15 -> 0 for WIDTH=4)
//       down: 0 -> 2**WIDTH-1   (e.g. 0 -> 15)
//   - Latency: UP_DOWN and pause are sampled at the edge. A change takes
//     effect on the first rising edge after it; no pipeline, no extra delay.
//   - Direction reversal needs no idle cycle. The edge after a flip moves
//     Q one step the new way from its current value.
//   - Reset released on or near a clk edge: the first count happens on the
//     next edge that sees reset=0. Synchronize the reset release upstream
//     if the design needs a deterministic first count.
//   - Reset mid-count: Q goes to 0 asynchronously; counting resumes from 0.
//   - Q is purely registered, with no combinational path from inputs to Q.
//   - No X propagation from pause/UP_DOWN while reset is active.
//
// STRUCTURE
//   - Single always block: async reset, then pause / up / down mux.
//   - No sub-module needed.
//   - Shared package (counter_pkg): default WIDTH constant and a typedef
//     for the count vector (count_t), for reuse by consumers of Q.
//
// TESTING  (WIDTH=4, clk period 20 ns)
//   1. reset=1 at t=0 -> Q=0 before any clk edge; Q stays 0 across edges.
//   2. Release reset, UP_DOWN=0, pause=0 from Q=0 -> Q = 15, 14, 13 on
//      successive edges (down wrap).
//   3. UP_DOWN=1 from Q=13 for 5 edges -> 14, 15, 0, 1, 2 (up wrap).
//   4. pause=1 for 3 edges, UP_DOWN toggling -> Q holds at 2.
//      pause=0, UP_DOWN=1 -> 3 on the next edge.
//   5. Flip UP_DOWN 1->0 at Q=7 -> next edge Q=6; no extra-cycle latency.
//   6. Assert reset between edges at Q=9 -> Q=0 immediately.
//      Deassert with UP_DOWN=1 -> Q = 1, 2 on the following edges.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and for any logic that
// consumes its count (displays, comparators, position trackers).
//
// Contents:
//   COUNTER_WIDTH  default counter width in bits
//   count_t        count vector type at the default width
package counter_pkg;

  localparam int COUNTER_WIDTH = 4;

  typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/up_down_counter.sv
// Free-running WIDTH-bit binary up/down counter with a hold control.
// Counts once per rising clk edge and wraps modulo 2**WIDTH in both
// directions (no saturation).
//
// Ports:
//   clk      in   1      system clock, rising-edge active
//   reset    in   1      asynchronous active-high reset, forces Q to 0
//   UP_DOWN  in   1      direction: 1 = increment, 0 = decrement
//   pause    in   1      1 = hold the current count, 0 = count
//   Q        out  WIDTH  current count, straight from the register
module up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             UP_DOWN,
  input  logic             pause,
  output logic [WIDTH-1:0] Q
);

  // Count register. Reset wins over everything and acts without a clock
  // edge; otherwise pause holds the value and UP_DOWN picks the step.
  // Plain WIDTH-bit add/subtract gives the wrap in both directions
  // (max -> 0 going up, 0 -> max going down) for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= '0;
    end else if (pause) begin
      Q <= Q;
    end else if (UP_DOWN) begin
      Q <= Q + 1'b1;
    end else begin
      Q <= Q - 1'b1;
    end
  end

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (WIDTH=4, 20 ns clock).
// A modulo-arithmetic model tracks the expected count and is compared
// against Q on every falling edge; directed steps also pin literal values.
module tb_up_down_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             UP_DOWN;
  logic             pause;
  logic [WIDTH-1:0] Q;

  int exp_q;
  int total;
  int bad;

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .UP_DOWN (UP_DOWN),
    .pause   (pause),
    .Q       (Q)
  );

  // 20 ns clock, first rising edge at 10 ns.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: asserting reset clears the expected count at once,
  // independent of the clock.
  always @(posedge reset) begin
    exp_q = 0;
  end

  // Reference model: on each rising edge the count holds, steps up or
  // steps down modulo 2**WIDTH, with reset taking priority over pause.
  always @(posedge clk) begin
    if (reset) begin
      exp_q = 0;
    end else if (!pause) begin
      if (UP_DOWN) exp_q = (exp_q + 1) % MOD;
      else         exp_q = (exp_q + MOD - 1) % MOD;
    end
  end

  // Continuous compare against the model, half a period after each
  // active edge so Q has settled.
  always @(negedge clk) begin
    total++;
    if (Q !== WIDTH'(exp_q)) begin
      bad++;
      $display("[TB] FAIL model_compare at %0t: Q=%0d expected=%0d", $time, Q, exp_q);
    end
  end

  // Drive all inputs together.
  task automatic applyStimulus(input logic r, input logic ud, input logic p);
    reset   = r;
    UP_DOWN = ud;
    pause   = p;
  endtask

  // Compare Q with a hand-computed literal.
  task automatic checkOutput(input string name, input int expected);
    total++;
    if (Q !== WIDTH'(expected)) begin
      bad++;
      $display("[TB] FAIL %s at %0t: Q=%0d expected=%0d", name, $time, Q, expected);
    end
  endtask

  // Advance one clock edge and check the literal just after the falling
  // edge, leaving time to change inputs well before the next rising edge.
  task automatic stepAndCheck(input string name, input int expected);
    @(negedge clk);
    #1;
    checkOutput(name, expected);
  endtask

  // Directed stimulus walking through the reset, wrap, hold, reversal and
  // mid-cycle reset scenarios.
  initial begin
    total = 0;
    bad   = 0;
    exp_q = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset clears Q before any clock edge and keeps it there.
    #1;
    checkOutput("reset_before_edge", 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepAndCheck("reset_hold_0", 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepAndCheck("reset_hold_1", 0);

    // Count down from 0 with wrap.
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepAndCheck("down_wrap", 15);
    stepAndCheck("down_14", 14);
    stepAndCheck("down_13", 13);

    // Count up through the top of the range.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepAndCheck("up_14", 14);
    stepAndCheck("up_15", 15);
    stepAndCheck("up_wrap", 0);
    stepAndCheck("up_1", 1);
    stepAndCheck("up_2", 2);

    // Hold while UP_DOWN toggles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, i[0], 1'b1);
      stepAndCheck("pause_hold", 2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepAndCheck("resume_up", 3);

    // Climb to 7, then reverse with no idle cycle.
    stepAndCheck("up_4", 4);
    stepAndCheck("up_5", 5);
    stepAndCheck("up_6", 6);
    stepAndCheck("up_7", 7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepAndCheck("reverse_down", 6);

    // Back up to 9 for the mid-cycle reset.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepAndCheck("up_7b", 7);
    stepAndCheck("up_8", 8);
    stepAndCheck("up_9", 9);

    // Assert reset between edges: Q clears without a clock edge.
    #4;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 0);
    stepAndCheck("reset_mid_hold", 0);

    // Release reset counting up: resumes from 0.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepAndCheck("post_reset_1", 1);
    stepAndCheck("post_reset_2", 2);

    // Pause at the bottom of the range, then wrap down from 0.
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepAndCheck("down_1", 1);
    stepAndCheck("down_0", 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepAndCheck("pause_at_0", 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepAndCheck("down_wrap_again", 15);

    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_up_down_counter
